l2_port_arbiter: RTL and testbench

Shares the single L2/memory block port between two L1 caches: requester 0 is the D-cache and requester 1 is the I-cache. It uses round-robin arbitration and locks the grant for a whole transaction. It registers the winning request onto the memory side and returns a one-cycle ready pulse, with the block data, to the owner only. It sits between the L1 instances and the L2/memory model and keeps per-requester transaction counters for performance reporting.

---
 rtl/l2_port_arbiter_if.sv | 64 ++++++
 rtl/l2_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_l2_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_port_arbiter_if.sv
// l2_port_arbiter_if
// Bundles every bus signal of the L2 port arbiter: the two L1 request ports
// (c0 = D-cache, c1 = I-cache), the shared memory-side port, and the status
// and counter outputs.
//
// Handshake: an L1 raises cN_read or cN_write (level) with a stable address
// and write block, and holds them until it sees cN_ready high for one
// cycle; cN_rdata is valid in that same cycle. Toward L2, mem_read or
// mem_write is held high with a stable address and write block until L2
// answers with a one-cycle mem_ready; mem_rdata is valid in that cycle.
//
// Modports:
//   master - environment side (L1 caches and L2 model): drives requests and
//            memory responses.
//   slave  - arbiter side: drives ready/rdata, memory strobes and status.
interface l2_port_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
);
  logic              c0_read;
  logic              c0_write;
  logic [ADDR_W-1:0] c0_addr;
  logic [DATA_W-1:0] c0_wdata;
  logic [DATA_W-1:0] c0_rdata;
  logic              c0_ready;

  logic              c1_read;
  logic              c1_write;
  logic [ADDR_W-1:0] c1_addr;
  logic [DATA_W-1:0] c1_wdata;
  logic [DATA_W-1:0] c1_rdata;
  logic              c1_ready;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              busy;
  logic              owner;
  logic [CNT_W-1:0]  c0_cnt;
  logic [CNT_W-1:0]  c1_cnt;

  modport master (
    output c0_read, c0_write, c0_addr, c0_wdata,
    output c1_read, c1_write, c1_addr, c1_wdata,
    output mem_rdata, mem_ready,
    input  c0_rdata, c0_ready, c1_rdata, c1_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    input  busy, owner, c0_cnt, c1_cnt
  );

  modport slave (
    input  c0_read, c0_write, c0_addr, c0_wdata,
    input  c1_read, c1_write, c1_addr, c1_wdata,
    input  mem_rdata, mem_ready,
    output c0_rdata, c0_ready, c1_rdata, c1_ready,
    output mem_read, mem_write, mem_addr, mem_wdata,
    output busy, owner, c0_cnt, c1_cnt
  );
endinterface

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter
// Shares one L2/memory block port between the D-cache (requester 0) and the
// I-cache (requester 1). Round-robin arbitration, grant locked for the whole
// transaction, registered memory-side request, one-cycle ready pulse with
// the returned block to the owner only, and per-requester completion
// counters.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   bus          l2_port_arbiter_if.slave: L1 ports, memory port, status,
//                counters
//   o_dbg_state  current FSM state (0 IDLE, 1 BUSY, 2 DONE)
module l2_port_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  l2_port_arbiter_if.slave    bus,
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic              r_rr_pri;
  logic              r_owner;
  logic              r_busy;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_c0_rdata;
  logic [DATA_W-1:0] r_c1_rdata;
  logic              r_c0_ready;
  logic              r_c1_ready;
  logic [CNT_W-1:0]  r_c0_cnt;
  logic [CNT_W-1:0]  r_c1_cnt;

  state_t            w_next_state;
  logic              w_grant;
  logic              w_complete;
  logic              w_req0;
  logic              w_req1;
  logic              w_winner;
  logic              w_win_read;
  logic              w_win_write;

  assign w_req0 = bus.c0_read | bus.c0_write;
  assign w_req1 = bus.c1_read | bus.c1_write;

  // Requester 1 wins when it is alone, or when both ask and it holds priority.
  assign w_winner    = w_req1 & (~w_req0 | r_rr_pri);
  assign w_win_write = w_winner ? bus.c1_write : bus.c0_write;
  // A simultaneous read+write is issued as a write only.
  assign w_win_read  = ~w_win_write & (w_winner ? bus.c1_read : bus.c0_read);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; grant and completion events are decoded here.
  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req0 | w_req1) begin
          w_grant      = 1'b1;
          w_next_state = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (bus.mem_ready) begin
          w_complete   = 1'b1;
          w_next_state = ST_DONE;
        end
      end
      // One dead cycle so the owner can drop its request before re-arbitration.
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_pri    <= 1'b0;
      r_owner     <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_c0_rdata  <= '0;
      r_c1_rdata  <= '0;
      r_c0_ready  <= 1'b0;
      r_c1_ready  <= 1'b0;
      r_c0_cnt    <= '0;
      r_c1_cnt    <= '0;
    end else begin
      r_busy     <= (w_next_state != ST_IDLE);
      r_c0_ready <= 1'b0;
      r_c1_ready <= 1'b0;

      if (w_grant) begin
        r_owner     <= w_winner;
        r_rr_pri    <= ~w_winner;
        r_mem_read  <= w_win_read;
        r_mem_write <= w_win_write;
        r_mem_addr  <= w_winner ? bus.c1_addr  : bus.c0_addr;
        r_mem_wdata <= w_winner ? bus.c1_wdata : bus.c0_wdata;
      end

      if (w_complete) begin
        r_mem_read  <= 1'b0;
        r_mem_write <= 1'b0;
        if (r_owner) begin
          r_c1_ready <= 1'b1;
          r_c1_rdata <= bus.mem_rdata;
          r_c1_cnt   <= r_c1_cnt + CNT_ONE;
        end else begin
          r_c0_ready <= 1'b1;
          r_c0_rdata <= bus.mem_rdata;
          r_c0_cnt   <= r_c0_cnt + CNT_ONE;
        end
      end
    end
  end

  assign bus.c0_rdata  = r_c0_rdata;
  assign bus.c0_ready  = r_c0_ready;
  assign bus.c1_rdata  = r_c1_rdata;
  assign bus.c1_ready  = r_c1_ready;
  assign bus.mem_read  = r_mem_read;
  assign bus.mem_write = r_mem_write;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.busy      = r_busy;
  assign bus.owner     = r_owner;
  assign bus.c0_cnt    = r_c0_cnt;
  assign bus.c1_cnt    = r_c1_cnt;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb_l2_port_arbiter
// Directed bench for l2_port_arbiter. Counters are built 8 bits wide here so
// the wrap case is reachable in a short run; all other widths are default.
module tb_l2_port_arbiter;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam int CNT_W  = 8;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  l2_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  l2_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [CNT_W-1:0]  exp_cnt0, exp_cnt1;
  logic [DATA_W-1:0] exp_rd0, exp_rd1;
  logic [0:0]        exp_q[$];   // expected grant order under contention

  typedef struct {
    logic              c0_rd, c0_wr, c1_rd, c1_wr;
    logic [ADDR_W-1:0] a0, a1;
    logic [DATA_W-1:0] wd0, wd1, rd;
    int                lat;
    logic              exp_owner, exp_rd, exp_wr;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_wdata;
  } vec_t;

  vec_t vecs[6];

  task automatic check_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b", name, act, exp);
  endtask

  task automatic check_w(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus.c0_read = 1'b0; bus.c0_write = 1'b0; bus.c0_addr = '0; bus.c0_wdata = '0;
    bus.c1_read = 1'b0; bus.c1_write = 1'b0; bus.c1_addr = '0; bus.c1_wdata = '0;
    bus.mem_rdata = '0; bus.mem_ready = 1'b0;
  endtask

  task automatic drop_reqs();
    bus.c0_read = 1'b0; bus.c0_write = 1'b0;
    bus.c1_read = 1'b0; bus.c1_write = 1'b0;
  endtask

  task automatic model_reset();
    exp_cnt0 = '0; exp_cnt1 = '0; exp_rd0 = '0; exp_rd1 = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Wait (bounded) for a memory strobe; returns negedges waited.
  task automatic wait_strobe(output int cycles, output logic seen);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!(bus.mem_read || bus.mem_write) && cycles < 20);
    seen = bus.mem_read || bus.mem_write;
    check_b("strobe_seen", seen, 1'b1);
  endtask

  // Pulse mem_ready for one cycle and check the completion outputs.
  task automatic complete(input logic own, input logic [DATA_W-1:0] rdata);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = rdata;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    if (own) begin exp_cnt1 = exp_cnt1 + 1'b1; exp_rd1 = rdata; end
    else     begin exp_cnt0 = exp_cnt0 + 1'b1; exp_rd0 = rdata; end
    check_b("c0_ready_pulse", bus.c0_ready, ~own);
    check_b("c1_ready_pulse", bus.c1_ready, own);
    check_w("c0_rdata", bus.c0_rdata, exp_rd0);
    check_w("c1_rdata", bus.c1_rdata, exp_rd1);
    check_w("c0_cnt", 128'(bus.c0_cnt), 128'(exp_cnt0));
    check_w("c1_cnt", 128'(bus.c1_cnt), 128'(exp_cnt1));
    check_b("mem_read_drop", bus.mem_read, 1'b0);
    check_b("mem_write_drop", bus.mem_write, 1'b0);
    check_b("busy_done", bus.busy, 1'b1);
    check_w("state_done", 128'(dbg_state), 128'd2);
  endtask

  // Apply one table vector from IDLE and run it to completion.
  task automatic run_vec(input vec_t v);
    bus.c0_read = v.c0_rd; bus.c0_write = v.c0_wr; bus.c0_addr = v.a0; bus.c0_wdata = v.wd0;
    bus.c1_read = v.c1_rd; bus.c1_write = v.c1_wr; bus.c1_addr = v.a1; bus.c1_wdata = v.wd1;
    @(negedge clk);
    check_b("grant_owner", bus.owner, v.exp_owner);
    check_b("mem_read", bus.mem_read, v.exp_rd);
    check_b("mem_write", bus.mem_write, v.exp_wr);
    check_w("mem_addr", 128'(bus.mem_addr), 128'(v.exp_addr));
    check_w("mem_wdata", bus.mem_wdata, v.exp_wdata);
    check_b("busy_busy", bus.busy, 1'b1);
    check_w("state_busy", 128'(dbg_state), 128'd1);
    for (int i = 0; i < v.lat; i++) begin
      // Requester inputs move while BUSY; the memory side must not.
      bus.c0_addr = ADDR_W'($urandom);
      bus.c1_addr = ADDR_W'($urandom);
      bus.c0_wdata = {4{$urandom}};
      bus.c1_wdata = {4{$urandom}};
      @(negedge clk);
      check_w("mem_addr_stable", 128'(bus.mem_addr), 128'(v.exp_addr));
      check_w("mem_wdata_stable", bus.mem_wdata, v.exp_wdata);
      check_b("no_early_ready", bus.c0_ready | bus.c1_ready, 1'b0);
    end
    complete(v.exp_owner, v.rd);
    drop_reqs();
    @(negedge clk);
    check_b("ready_one_cycle", bus.c0_ready | bus.c1_ready, 1'b0);
    check_b("busy_idle", bus.busy, 1'b0);
  endtask

  function automatic vec_t mk(input logic c0r, c0w, c1r, c1w,
                              input logic [ADDR_W-1:0] a0, a1,
                              input logic [DATA_W-1:0] wd0, wd1, rd,
                              input int lat, input logic own, er, ew,
                              input logic [ADDR_W-1:0] ea,
                              input logic [DATA_W-1:0] ewd);
    vec_t v;
    v.c0_rd = c0r; v.c0_wr = c0w; v.c1_rd = c1r; v.c1_wr = c1w;
    v.a0 = a0; v.a1 = a1; v.wd0 = wd0; v.wd1 = wd1; v.rd = rd; v.lat = lat;
    v.exp_owner = own; v.exp_rd = er; v.exp_wr = ew; v.exp_addr = ea; v.exp_wdata = ewd;
    return v;
  endfunction

  // ---------------- test ----------------
  initial begin
    int   cyc;
    logic seen;
    logic own;
    logic [DATA_W-1:0] a5;
    a5 = {16{8'hA5}};

    // Table: rr priority starts at 0 after reset and flips to ~winner per grant.
    //             c0r c0w c1r c1w  a0            a1            wd0                 wd1                 rd                  lat own rd wr  addr          wdata
    vecs[0] = mk(1, 0, 0, 0, 28'h0000123, 28'h0000000, '0,                 '0,                 a5,                 3, 0, 1, 0, 28'h0000123, '0);
    vecs[1] = mk(0, 0, 1, 1, 28'h0000000, 28'h0ABCDEF, '0,                 {4{32'h11112222}},  {4{32'h0F0F0F0F}},  2, 1, 0, 1, 28'h0ABCDEF, {4{32'h11112222}});
    vecs[2] = mk(1, 0, 1, 0, 28'h0000200, 28'h0000300, {4{32'hCAFE0001}},  {4{32'hBEEF0002}},  {4{32'h12345678}},  1, 0, 1, 0, 28'h0000200, {4{32'hCAFE0001}});
    vecs[3] = mk(0, 1, 1, 0, 28'h0000400, 28'h0000500, {4{32'hCAFE0003}},  {4{32'hBEEF0004}},  {4{32'h9ABCDEF0}},  0, 1, 1, 0, 28'h0000500, {4{32'hBEEF0004}});
    vecs[4] = mk(0, 0, 1, 0, 28'h0000600, 28'h0FFFFFF, '0,                 '0,                 {4{32'h55AA55AA}},  2, 1, 1, 0, 28'h0FFFFFF, '0);
    vecs[5] = mk(0, 1, 0, 1, 28'h0000700, 28'h0000800, {4{32'hDEAD0005}},  {4{32'hBEEF0006}},  {4{32'h00000001}},  1, 0, 0, 1, 28'h0000700, {4{32'hDEAD0005}});

    // Reset state, sampled while reset is still asserted.
    reset_n = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    check_b("rst_mem_read", bus.mem_read, 1'b0);
    check_b("rst_mem_write", bus.mem_write, 1'b0);
    check_w("rst_mem_addr", 128'(bus.mem_addr), 128'd0);
    check_w("rst_mem_wdata", bus.mem_wdata, 128'd0);
    check_b("rst_busy", bus.busy, 1'b0);
    check_b("rst_owner", bus.owner, 1'b0);
    check_b("rst_ready", bus.c0_ready | bus.c1_ready, 1'b0);
    check_w("rst_c0_rdata", bus.c0_rdata, 128'd0);
    check_w("rst_c1_rdata", bus.c1_rdata, 128'd0);
    check_w("rst_c0_cnt", 128'(bus.c0_cnt), 128'd0);
    check_w("rst_c1_cnt", 128'(bus.c1_cnt), 128'd0);
    check_w("rst_state", 128'(dbg_state), 128'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check_b("idle_no_strobe", bus.mem_read | bus.mem_write, 1'b0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Contention: both hold reads for six transactions from a fresh reset.
    do_reset();
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    bus.c0_read = 1'b1; bus.c0_addr = 28'h0000AAA;
    bus.c1_read = 1'b1; bus.c1_addr = 28'h0000BBB;
    for (int t = 0; t < 6; t++) begin
      wait_strobe(cyc, seen);
      if (!seen) break;
      // First grant lands one edge after the request; later ones need DONE+IDLE.
      check_w("turnaround", 128'(cyc), (t == 0) ? 128'd1 : 128'd2);
      own = exp_q.pop_front();
      check_b("rr_owner", bus.owner, own);
      check_w("rr_addr", 128'(bus.mem_addr), own ? 128'h0000BBB : 128'h0000AAA);
      complete(own, {4{32'(t + 32'h100)}});
    end
    drop_reqs();
    @(negedge clk);
    check_w("cont_c0_cnt", 128'(bus.c0_cnt), 128'd3);
    check_w("cont_c1_cnt", 128'(bus.c1_cnt), 128'd3);

    // Reset while BUSY: everything clears without waiting for a clock edge.
    bus.c0_read = 1'b1; bus.c0_addr = 28'h0000456;
    @(negedge clk);
    check_b("pre_rst_mem_read", bus.mem_read, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_b("async_mem_read", bus.mem_read, 1'b0);
    check_b("async_busy", bus.busy, 1'b0);
    check_w("async_c0_cnt", 128'(bus.c0_cnt), 128'd0);
    check_w("async_c1_cnt", 128'(bus.c1_cnt), 128'd0);
    check_w("async_state", 128'(dbg_state), 128'd0);
    model_reset();
    drop_reqs();
    @(negedge clk);
    reset_n = 1'b1;
    // Spurious mem_ready in IDLE.
    bus.mem_ready = 1'b1;
    bus.mem_rdata = {4{32'hFFFF0000}};
    @(negedge clk);
    bus.mem_ready = 1'b0;
    check_b("spur_ready", bus.c0_ready | bus.c1_ready, 1'b0);
    check_b("spur_busy", bus.busy, 1'b0);
    check_w("spur_c0_rdata", bus.c0_rdata, 128'd0);
    repeat (2) @(negedge clk);
    check_b("post_rst_ready", bus.c0_ready | bus.c1_ready, 1'b0);
    check_w("spur_c0_cnt", 128'(bus.c0_cnt), 128'd0);
    check_w("spur_c1_cnt", 128'(bus.c1_cnt), 128'd0);
    run_vec(mk(1, 0, 0, 0, 28'h0000456, 28'h0, '0, '0, {4{32'h600DF00D}}, 2, 0, 1, 0, 28'h0000456, '0));

    // Counter wrap: c0 alone, back-to-back until the counter rolls over.
    bus.c0_read = 1'b1; bus.c0_addr = 28'h0000999;
    while (exp_cnt0 != {CNT_W{1'b1}}) begin
      wait_strobe(cyc, seen);
      if (!seen) break;
      bus.mem_ready = 1'b1;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      exp_cnt0 = exp_cnt0 + 1'b1;
    end
    check_w("cnt_at_max", 128'(bus.c0_cnt), 128'(exp_cnt0));
    wait_strobe(cyc, seen);
    complete(1'b0, {4{32'h77777777}});
    drop_reqs();
    check_w("cnt_wrapped", 128'(bus.c0_cnt), 128'd0);
    check_w("c1_cnt_untouched", 128'(bus.c1_cnt), 128'd0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
